// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte size, ACK/NACK levels, target receiver states and
// the address-match helper used by the target.
package i2c_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam logic [3:0]  BYTE_BITS     = 4'(BITS_PER_BYTE);

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Target receiver state encoding
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAddr    = 3'd1,
    StAddrAck = 3'd2,
    StData    = 3'd3,
    StDataAck = 3'd4,
    StIgnore  = 3'd5
  } rx_state_e;

  // True when an address byte selects this target for a write (R/W bit = 0)
  function automatic logic addr_write_match(input logic [7:0] addr_byte,
                                            input logic [6:0] own_addr);
    return (addr_byte[7:1] == own_addr) && (addr_byte[0] == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input conditioning: multi-flop synchronizers preset to the idle bus
// level, a delay flop per line, and edge / START / STOP detection on the
// synchronized values.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_cond,
  output logic stop_cond
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;

  // Synchronizer chains and delay flops; reset to 1 so an idle bus shows no edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Edge and bus-condition decode; START/STOP need SCL high on both samples so a
  // simultaneous SCL+SDA change counts as a clock edge carrying data
  always_comb begin
    scl_rise   = scl_s & ~scl_d;
    scl_fall   = ~scl_s & scl_d;
    start_cond = scl_s & scl_d & sda_d & ~sda_s;
    stop_cond  = scl_s & scl_d & ~sda_d & sda_s;
  end

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: matches a 7-bit address, ACKs the address and every
// data byte by pulling SDA low, and presents each received byte as a one-clk
// rx_valid pulse.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h3C,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addressed,
  output logic       start_det,
  output logic       stop_det
);

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;
  logic       unused_scl_s;

  rx_state_e  state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] shift_nxt;
  logic       ack_pend;
  logic       sda_oe;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (SCL),
    .sda_in     (SDA),
    .scl_s      (scl_s),
    .sda_s      (sda_s),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_cond (start_cond),
    .stop_cond  (stop_cond)
  );

  // Level of SCL itself is not needed; only its edges drive the FSM
  assign unused_scl_s = scl_s;

  // Open-drain data line: only ever pulled low, during the ACK bit
  assign SDA = sda_oe ? ACK : 1'bz;

  assign shift_nxt = {shift[6:0], sda_s};

  // Receive FSM with registered outputs; START/STOP override SCL edge processing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      bit_cnt   <= '0;
      shift     <= '0;
      ack_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      addressed <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;

      if (start_cond) begin
        start_det <= 1'b1;
        bit_cnt   <= '0;
        shift     <= '0;
        ack_pend  <= 1'b0;
        addressed <= 1'b0;
        sda_oe    <= 1'b0;
        state     <= StAddr;
      end else if (stop_cond) begin
        stop_det  <= 1'b1;
        ack_pend  <= 1'b0;
        addressed <= 1'b0;
        sda_oe    <= 1'b0;
        state     <= StIdle;
      end else begin
        case (state)
          StAddr: begin
            if (scl_rise && (bit_cnt < BYTE_BITS)) begin
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == BYTE_BITS - 4'd1) begin
                ack_pend <= addr_write_match(shift_nxt, TARGET_ADDR);
              end
            end else if (scl_fall && (bit_cnt == BYTE_BITS)) begin
              ack_pend <= 1'b0;
              if (ack_pend) begin
                sda_oe    <= 1'b1;
                addressed <= 1'b1;
                state     <= StAddrAck;
              end else begin
                state <= StIgnore;
              end
            end
          end

          StData: begin
            if (scl_rise && (bit_cnt < BYTE_BITS)) begin
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == BYTE_BITS - 4'd1) begin
                rx_data  <= shift_nxt;
                rx_valid <= 1'b1;
              end
            end else if (scl_fall && (bit_cnt == BYTE_BITS)) begin
              sda_oe <= 1'b1;
              state  <= StDataAck;
            end
          end

          // ACK is held through the 9th SCL high phase and dropped on its fall
          StAddrAck, StDataAck: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= StData;
            end
          end

          // StIdle and StIgnore only leave through START/STOP
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: a bit-banged I2C master drives SCL/SDA and
// every check is an immediate assertion against hand-computed values.
module tb_i2c_target_rx;

  localparam int Q = 20; // quarter bit period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m_low = 1'b0;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addressed;
  logic       start_det;
  logic       stop_det;

  int         checks = 0;
  int         errors = 0;
  int         rxv_cycles = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         dut_low_cnt = 0;
  logic [7:0] rx_q[$];
  logic       ack;
  int         base_start;
  int         base_stop;
  int         base_low;

  assign sda_bus = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_target_rx #(
    .TARGET_ADDR (7'h3C),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .SCL       (scl),
    .SDA       (sda_bus),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .addressed (addressed),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  always @(posedge clk) begin
    if (rx_valid) begin
      rxv_cycles <= rxv_cycles + 1;
      rx_q.push_back(rx_data);
    end
    if (start_det) start_cnt <= start_cnt + 1;
    if (stop_det) stop_cnt <= stop_cnt + 1;
    if (!sda_m_low && (sda_bus === 1'b0)) dut_low_cnt <= dut_low_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    sda_m_low = 1'b1; wait_q();
    scl = 1'b0;       wait_q();
  endtask

  task automatic bus_stop();
    sda_m_low = 1'b1; wait_q();
    scl = 1'b1;       wait_q();
    sda_m_low = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m_low = ~b; wait_q();
    scl = 1'b1;     wait_q(); wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_o);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    ack_o = sda_bus;  wait_q();
    scl = 1'b0;       wait_q();
  endtask

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_outputs", {20'd0, rx_valid, addressed, start_det, stop_det, rx_data}, 32'd0);
    check("rst_sda_released", sda_bus, 1'b1);
    reset = 1'b1;
    wait_q();

    // T1: 0x78 write, data 0xA5
    bus_start();
    check("t1_start_det", start_cnt, 1);
    send_byte(8'h78, ack);
    check("t1_addr_ack", ack, 1'b0);
    check("t1_addressed", addressed, 1'b1);
    send_byte(8'hA5, ack);
    check("t1_data_ack", ack, 1'b0);
    check("t1_rx_count", rxv_cycles, 1);
    check("t1_rx_data", rx_data, 8'hA5);
    bus_stop();
    check("t1_addressed_clr", addressed, 1'b0);
    check("t1_stop_det", stop_cnt, 1);
    check("t1_start_total", start_cnt, 1);

    // T2: wrong address 0x52 write -> NACK, nothing received
    base_low = dut_low_cnt;
    bus_start();
    send_byte(8'hA4, ack);
    check("t2_addr_nack", ack, 1'b1);
    send_byte(8'h11, ack);
    check("t2_data_nack", ack, 1'b1);
    check("t2_addressed", addressed, 1'b0);
    bus_stop();
    check("t2_never_low", dut_low_cnt - base_low, 0);
    check("t2_rx_count", rxv_cycles, 1);

    // T3: read request to own address -> NACK, ignored until STOP
    bus_start();
    send_byte(8'h79, ack);
    check("t3_addr_nack", ack, 1'b1);
    send_byte(8'h55, ack);
    check("t3_data_nack", ack, 1'b1);
    check("t3_addressed", addressed, 1'b0);
    bus_stop();
    check("t3_rx_count", rxv_cycles, 1);

    // T4: three data bytes
    bus_start();
    send_byte(8'h78, ack);
    check("t4_addr_ack", ack, 1'b0);
    send_byte(8'h12, ack);
    check("t4_ack0", ack, 1'b0);
    send_byte(8'h34, ack);
    check("t4_ack1", ack, 1'b0);
    send_byte(8'hFF, ack);
    check("t4_ack2", ack, 1'b0);
    bus_stop();
    check("t4_rx_count", rxv_cycles, 4);
    check("t4_byte0", rx_q[1], 8'h12);
    check("t4_byte1", rx_q[2], 8'h34);
    check("t4_byte2", rx_q[3], 8'hFF);

    // T5: partial byte then STOP, then partial byte then repeated START
    bus_start();
    send_byte(8'h78, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus_stop();
    check("t5_partial_no_rx", rxv_cycles, 4);
    check("t5_partial_addr", addressed, 1'b0);
    check("t5_partial_held", rx_data, 8'hFF);
    base_start = start_cnt;
    bus_start();
    send_byte(8'h78, ack);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bus_start();
    check("t5_rstart_cnt", start_cnt - base_start, 2);
    check("t5_rstart_addr_clr", addressed, 1'b0);
    send_byte(8'h78, ack);
    check("t5_rstart_addr_ack", ack, 1'b0);
    send_byte(8'h5A, ack);
    check("t5_rstart_data_ack", ack, 1'b0);
    check("t5_rx_data", rx_data, 8'h5A);
    check("t5_rx_count", rxv_cycles, 5);
    bus_stop();

    // T6: reset while the target holds SDA low in the data ACK bit
    bus_start();
    send_byte(8'h78, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hC3 >> i));
    check("t6_rx_data", rx_data, 8'hC3);
    sda_m_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    check("t6_ack_held", sda_bus, 1'b0);
    reset = 1'b0;
    #1;
    check("t6_sda_released", sda_bus, 1'b1);
    check("t6_outputs_zero", {20'd0, rx_valid, addressed, start_det, stop_det, rx_data}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_q();
    scl = 1'b0; wait_q();
    base_low  = dut_low_cnt;
    base_stop = stop_cnt;
    send_byte(8'h78, ack);
    check("t6_after_rst_nack", ack, 1'b1);
    check("t6_after_rst_addr", addressed, 1'b0);
    bus_stop();
    check("t6_never_low", dut_low_cnt - base_low, 0);
    check("t6_stop_det", stop_cnt - base_stop, 1);
    check("t6_rx_count", rxv_cycles, 6);
    check("t6_rx_data_zero", rx_data, 8'h00);
    check("t6_last_byte", rx_q[5], 8'hC3);
    check("rx_total", rx_q.size(), 6);
    check("rx_first", rx_q[0], 8'hA5);
    check("rx_fifth", rx_q[4], 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target (slave). It is the receiving end of the existing single-master I2C write engine.
- Samples SCL/SDA with the system clock and detects START and STOP conditions.
- Matches a 7-bit address and ACKs matched write bytes by pulling SDA low.
- Presents each received data byte as a one-cycle valid pulse to local logic, e.g. an LED/register sink on the same FPGA or a second board.

Parameters:
- TARGET_ADDR, 7'h3C, 7-bit address this target responds to.
- SYNC_STAGES, 2, synchronizer flop depth on SCL and SDA inputs (minimum 2).

Ports:
- clk  input  1  system clock (100 MHz nominal).
- reset  input  1  asynchronous, active-low reset.
- SCL  input  1  I2C clock from master (no clock stretching).
- SDA  inout  1  open-drain data line; driven only as 0 or Z.
- rx_data  output  8  last received data byte; held until the next byte completes.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- addressed  output  1  high from the ACKed address byte until STOP or repeated START.
- start_det  output  1  one-clk pulse on each START or repeated START.
- stop_det  output  1  one-clk pulse on each STOP.

Behaviour:
- Reset (async, active-low): all outputs 0; SDA released (Z); state IDLE; synchronizer flops preset to 1 (bus idle).
- Input conditioning: SCL and SDA each pass through SYNC_STAGES flops plus one delay flop for edge detection. A pin change is therefore seen internally SYNC_STAGES+1 clks later, and all decisions use the synchronized values.
- START: synced SDA falls while synced SCL is high. Valid in any state. Action: start_det pulse, bit_cnt=0, shift reg cleared, addressed=0, SDA released, go to ADDR.
- STOP: synced SDA rises while synced SCL is high. Valid in any state. Action: stop_det pulse, addressed=0, SDA released, go to IDLE. A partial byte is discarded with no rx_valid.
- Data sampling: on each synced SCL rising edge in ADDR or DATA, shift SDA in MSB-first and increment bit_cnt (4-bit). SDA changes while SCL is low are data, never START/STOP.
- State machine (states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE):
  - IDLE: wait for START.
  - ADDR: after the 8th SCL rise, compare shift[7:1] with TARGET_ADDR. On match with shift[0]=0, set ack_pend. Otherwise go to IGNORE on the next SCL fall.
  - At the SCL fall following the 8th rise with ack_pend set: drive SDA low and enter ADDR_ACK. Set addressed=1 at this same fall.
  - ADDR_ACK / DATA_ACK: hold SDA low through the 9th SCL high phase. At the next SCL fall, release SDA, set bit_cnt=0, go to DATA.
  - DATA: after the 8th SCL rise, rx_data<=shift and rx_valid=1 for exactly one clk, in the clk after the rise detect. At the following SCL fall, drive SDA low and enter DATA_ACK. Every data byte is ACKed; there is no NACK on data.
  - IGNORE: never drive SDA. Leave only via START or STOP. Covers address mismatch and read requests (R/W=1 gets NACK).
- Release rule: SDA is low only in ADDR_ACK/DATA_ACK. Leaving those states for any reason (START, STOP, reset) releases SDA in the same clk.
- Simultaneous events: START/STOP take priority over SCL edge processing in the same clk. SCL and SDA edges in the same clk are treated as SCL edge plus data.
- Reset mid-transfer: SDA released asynchronously. After reset the block waits in IDLE for a fresh START and ignores the rest of the transfer.
- Timing margin: the master's quarter-bit phase is 250 clks, far above the synchronizer latency.

Decomposition:
- Package i2c_pkg: state encoding localparams (shared with the master), ACK=1'b0, NACK=1'b1, BITS_PER_BYTE=8.
- Sub-module i2c_bus_sync: SYNC_STAGES synchronizer plus delay flop for SCL and SDA. Outputs scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond.

Test Plan:
- START, addr byte 0x78 (0x3C, W), data 0xA5, STOP -> SDA low during both 9th clocks; one rx_valid with rx_data=0xA5; addressed 1→0 at STOP; one start_det and one stop_det.
- Addr byte 0xA4 (0x52, W), data 0x11 -> SDA never driven low (NACK); rx_valid never asserts; addressed stays 0.
- Addr byte 0x79 (0x3C, R) -> NACK; state IGNORE until STOP; no rx_valid.
- START, 0x78, data 0x12, 0x34, 0xFF, STOP -> three rx_valid pulses with rx_data 0x12, 0x34, 0xFF in order; three data ACKs.
- START, 0x78, 4 data bits, then STOP -> no rx_valid; IDLE. Repeat with a repeated START after 4 bits followed by 0x78, 0x5A -> start_det twice; rx_data=0x5A.
- Assert reset while SDA is held low in DATA_ACK -> SDA goes Z immediately; all outputs 0; the remaining bits of that transfer produce no response.
